// File: rtl/stdp_pkg.sv
// Shared types and arithmetic helpers for the STDP weight-update scheduler.
package stdp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_READ  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } stdp_sched_state_t;

  function automatic int unsigned wmax(input int unsigned wres);
    return (32'd1 << wres) - 32'd1;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned w, input int unsigned wm);
    return (w >= wm) ? wm : w + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned w);
    return (w == 32'd0) ? 32'd0 : w - 32'd1;
  endfunction

endpackage

// File: rtl/stdp_update_sched_stabilize_func.sv
// Stabilization gate: weight w in 1..wmax-1 selects its own BRV, endpoints never gate.
module stabilize_func #(
  parameter int WRES = 3
) (
  input  logic [WRES-1:0]       w,
  input  logic [(1<<WRES)-3:0]  f_brv,
  output logic                  g
);
  localparam logic [WRES-1:0] WTOP = {WRES{1'b1}};

  logic [WRES-1:0] sel_s;

  always_comb begin
    sel_s = w - {{(WRES-1){1'b0}}, 1'b1};
    if ((w != {WRES{1'b0}}) && (w != WTOP)) begin
      g = f_brv[sel_s];
    end else begin
      g = 1'b0;
    end
  end

endmodule

// File: rtl/stdp_update_sched.sv
// Walks one neuron's synapses and applies gated, saturating STDP updates via RMW on the weight RAM.
module stdp_update_sched
  import stdp_pkg::*;
#(
  parameter int WRES = 3,
  parameter int NSYN = 8,
  parameter int AW   = $clog2(NSYN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NSYN-1:0]       inc_req,
  input  logic [NSYN-1:0]       dec_req,
  input  logic [(1<<WRES)-3:0]  F_brv,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_addr,
  input  logic [WRES-1:0]       mem_rd_data,
  output logic [WRES-1:0]       mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [AW:0]           upd_cnt
);
  localparam int unsigned   WMAX = wmax(WRES);
  localparam logic [AW-1:0] LAST = AW'(NSYN - 1);

  stdp_sched_state_t state_q, state_d;
  logic [NSYN-1:0]   inc_q, inc_d, dec_q, dec_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WRES-1:0]   wr_data_q, wr_data_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [AW:0]       upd_cnt_q, upd_cnt_d;

  logic              g_s;
  logic [WRES-1:0]   nw_s;
  int unsigned       w_i, nw_i;

  stabilize_func #(.WRES(WRES)) u_stab (
    .w     (mem_rd_data),
    .f_brv (F_brv),
    .g     (g_s)
  );

  // Endpoints move unconditionally toward the interior; interior steps need the gate.
  always_comb begin
    w_i = 32'(mem_rd_data);
    if (inc_q[idx_q]) begin
      if ((w_i == 32'd0) || g_s) begin
        nw_i = sat_inc(w_i, WMAX);
      end else begin
        nw_i = w_i;
      end
    end else begin
      if ((w_i == WMAX) || g_s) begin
        nw_i = sat_dec(w_i);
      end else begin
        nw_i = w_i;
      end
    end
    nw_s = WRES'(nw_i);
  end

  // Next-state logic; strobes are computed one cycle early so they are registered in the state that owns them.
  always_comb begin
    state_d   = state_q;
    inc_d     = inc_q;
    dec_d     = dec_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    addr_d    = '0;
    wr_data_d = '0;
    upd_cnt_d = upd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          inc_d   = inc_req;
          dec_d   = dec_req;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (inc_q[idx_q] ^ dec_q[idx_q]) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
          addr_d  = idx_q;
        end else if (idx_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
        end
      end
      ST_READ: begin
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d   = ST_WRITE;
        wr_en_d   = 1'b1;
        addr_d    = idx_q;
        wr_data_d = nw_s;
        if (nw_s != mem_rd_data) begin
          cnt_d = cnt_q + (AW+1)'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WRITE: begin
        if (idx_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      upd_cnt_d = cnt_d;
    end else begin
      upd_cnt_d = upd_cnt_q;
    end
  end

  // Single state register; reset aborts any pass and suppresses the pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      inc_q     <= '0;
      dec_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      upd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign upd_cnt     = upd_cnt_q;

endmodule
